// File: rtl/ysyx_20020207_axi_arbiter_pkg.sv
// Shared types for the IFU/LSU -> xbar AXI-lite arbiter: FSM encoding, read-owner
// tag, AXI response codes and the read-tie-break helper.
package ysyx_20020207_axi_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_IFU_RD = 2'd1,
    ARB_LSU_RD = 2'd2,
    ARB_LSU_WR = 2'd3
  } arb_state_e;

  typedef enum logic {
    RD_IFU = 1'b0,
    RD_LSU = 1'b1
  } rd_owner_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Read arbitration: on a tie the master that did not own the last read wins.
  function automatic arb_state_e pick_read(input logic ifu_req, input logic lsu_req,
                                           input rd_owner_e last_rd);
    if (ifu_req && lsu_req) return (last_rd == RD_IFU) ? ARB_LSU_RD : ARB_IFU_RD;
    else if (lsu_req)       return ARB_LSU_RD;
    else if (ifu_req)       return ARB_IFU_RD;
    else                    return ARB_IDLE;
  endfunction

endpackage

// File: rtl/ysyx_20020207_arb_rdmux.sv
// Read-channel (AR/R) steering between the two read masters and the xbar.
// Only the selected owner is connected; the other sees all-zero outputs.
module ysyx_20020207_arb_rdmux #(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic          sel_ifu,
  input  logic          sel_lsu,
  input  logic          ifu_arvalid,
  input  logic [AW-1:0] ifu_araddr,
  input  logic          ifu_rready,
  output logic          ifu_arready,
  output logic          ifu_rvalid,
  output logic [1:0]    ifu_rresp,
  output logic [DW-1:0] ifu_rdata,
  input  logic          lsu_arvalid,
  input  logic [AW-1:0] lsu_araddr,
  input  logic          lsu_rready,
  output logic          lsu_arready,
  output logic          lsu_rvalid,
  output logic [1:0]    lsu_rresp,
  output logic [DW-1:0] lsu_rdata,
  output logic          xb_arvalid,
  output logic [AW-1:0] xb_araddr,
  output logic          xb_rready,
  input  logic          xb_arready,
  input  logic          xb_rvalid,
  input  logic [1:0]    xb_rresp,
  input  logic [DW-1:0] xb_rdata
);

  always_comb begin
    xb_arvalid  = 1'b0;
    xb_araddr   = '0;
    xb_rready   = 1'b0;
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    ifu_rresp   = '0;
    ifu_rdata   = '0;
    lsu_arready = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_rresp   = '0;
    lsu_rdata   = '0;
    if (sel_ifu) begin
      xb_arvalid  = ifu_arvalid;
      xb_araddr   = ifu_araddr;
      xb_rready   = ifu_rready;
      ifu_arready = xb_arready;
      ifu_rvalid  = xb_rvalid;
      ifu_rresp   = xb_rresp;
      ifu_rdata   = xb_rdata;
    end else if (sel_lsu) begin
      xb_arvalid  = lsu_arvalid;
      xb_araddr   = lsu_araddr;
      xb_rready   = lsu_rready;
      lsu_arready = xb_arready;
      lsu_rvalid  = xb_rvalid;
      lsu_rresp   = xb_rresp;
      lsu_rdata   = xb_rdata;
    end
  end

endmodule

// File: rtl/ysyx_20020207_axi_arbiter.sv
// 2-master (IFU read-only, LSU read/write) -> 1-slave AXI-lite arbiter, one
// single-beat transaction in flight; owner holds the xbar until its R/B handshake.
module ysyx_20020207_axi_arbiter
  import ysyx_20020207_axi_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic            clock,
  input  logic            rst_n,
  input  logic            ifu_arvalid,
  input  logic [AW-1:0]   ifu_araddr,
  output logic            ifu_arready,
  output logic            ifu_rvalid,
  output logic [1:0]      ifu_rresp,
  output logic [DW-1:0]   ifu_rdata,
  input  logic            ifu_rready,
  input  logic            lsu_arvalid,
  input  logic [AW-1:0]   lsu_araddr,
  output logic            lsu_arready,
  output logic            lsu_rvalid,
  output logic [1:0]      lsu_rresp,
  output logic [DW-1:0]   lsu_rdata,
  input  logic            lsu_rready,
  input  logic            lsu_awvalid,
  input  logic [AW-1:0]   lsu_awaddr,
  input  logic            lsu_wvalid,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wstrb,
  output logic            lsu_awready,
  output logic            lsu_wready,
  output logic            lsu_bvalid,
  output logic [1:0]      lsu_bresp,
  input  logic            lsu_bready,
  output logic            xb_arvalid,
  output logic [AW-1:0]   xb_araddr,
  output logic            xb_rready,
  output logic            xb_awvalid,
  output logic [AW-1:0]   xb_awaddr,
  output logic            xb_wvalid,
  output logic [DW-1:0]   xb_wdata,
  output logic [DW/8-1:0] xb_wstrb,
  output logic            xb_bready,
  input  logic            xb_arready,
  input  logic            xb_rvalid,
  input  logic [1:0]      xb_rresp,
  input  logic [DW-1:0]   xb_rdata,
  input  logic            xb_awready,
  input  logic            xb_wready,
  input  logic            xb_bvalid,
  input  logic [1:0]      xb_bresp,
  output arb_state_e      dbg_state
);

  // Handshakes: a transfer happens on a rising clock edge where valid and ready are
  // both high; a master keeps valid and payload stable until then, ready may toggle.
  arb_state_e state, state_nxt;
  rd_owner_e  last_rd, last_rd_nxt;
  logic       aw_done, aw_done_nxt;
  logic       w_done, w_done_nxt;
  logic       aw_fire, w_fire;

  assign dbg_state = state;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB_IDLE;
      last_rd <= RD_IFU;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      last_rd <= last_rd_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
    end
  end

  ysyx_20020207_arb_rdmux #(.AW(AW), .DW(DW)) u_rdmux (
    .sel_ifu     (state == ARB_IFU_RD),
    .sel_lsu     (state == ARB_LSU_RD),
    .ifu_arvalid (ifu_arvalid),
    .ifu_araddr  (ifu_araddr),
    .ifu_rready  (ifu_rready),
    .ifu_arready (ifu_arready),
    .ifu_rvalid  (ifu_rvalid),
    .ifu_rresp   (ifu_rresp),
    .ifu_rdata   (ifu_rdata),
    .lsu_arvalid (lsu_arvalid),
    .lsu_araddr  (lsu_araddr),
    .lsu_rready  (lsu_rready),
    .lsu_arready (lsu_arready),
    .lsu_rvalid  (lsu_rvalid),
    .lsu_rresp   (lsu_rresp),
    .lsu_rdata   (lsu_rdata),
    .xb_arvalid  (xb_arvalid),
    .xb_araddr   (xb_araddr),
    .xb_rready   (xb_rready),
    .xb_arready  (xb_arready),
    .xb_rvalid   (xb_rvalid),
    .xb_rresp    (xb_rresp),
    .xb_rdata    (xb_rdata)
  );

  // AW and W may complete in either order; a finished channel is masked until B.
  assign aw_fire = (state == ARB_LSU_WR) && lsu_awvalid && !aw_done && xb_awready;
  assign w_fire  = (state == ARB_LSU_WR) && lsu_wvalid && !w_done && xb_wready;

  always_comb begin
    state_nxt   = state;
    last_rd_nxt = last_rd;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    xb_awvalid  = 1'b0;
    xb_awaddr   = '0;
    xb_wvalid   = 1'b0;
    xb_wdata    = '0;
    xb_wstrb    = '0;
    xb_bready   = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    lsu_bresp   = '0;
    unique case (state)
      ARB_IDLE: begin
        if (lsu_awvalid || lsu_wvalid) state_nxt = ARB_LSU_WR;
        else state_nxt = pick_read(ifu_arvalid, lsu_arvalid, last_rd);
      end
      ARB_IFU_RD: begin
        if (xb_rvalid && ifu_rready) begin
          state_nxt   = ARB_IDLE;
          last_rd_nxt = RD_IFU;
        end
      end
      ARB_LSU_RD: begin
        if (xb_rvalid && lsu_rready) begin
          state_nxt   = ARB_IDLE;
          last_rd_nxt = RD_LSU;
        end
      end
      ARB_LSU_WR: begin
        xb_awvalid  = lsu_awvalid && !aw_done;
        xb_awaddr   = lsu_awaddr;
        lsu_awready = xb_awready && !aw_done;
        xb_wvalid   = lsu_wvalid && !w_done;
        xb_wdata    = lsu_wdata;
        xb_wstrb    = lsu_wstrb;
        lsu_wready  = xb_wready && !w_done;
        xb_bready   = lsu_bready;
        lsu_bvalid  = xb_bvalid;
        lsu_bresp   = xb_bresp;
        if (aw_fire) aw_done_nxt = 1'b1;
        if (w_fire)  w_done_nxt  = 1'b1;
        if (xb_bvalid && lsu_bready) begin
          state_nxt   = ARB_IDLE;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_20020207_axi_arbiter.sv
// Randomized scoreboard bench for the IFU/LSU AXI-lite arbiter with a behavioural
// xbar slave and a transaction-order reference model.
module tb_ysyx_20020207_axi_arbiter;
  import ysyx_20020207_axi_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = DW / 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  logic          ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic [AW-1:0] ifu_araddr;
  logic [1:0]    ifu_rresp;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [AW-1:0] lsu_araddr, lsu_awaddr;
  logic [1:0]    lsu_rresp, lsu_bresp;
  logic [DW-1:0] lsu_rdata, lsu_wdata;
  logic          lsu_awvalid, lsu_wvalid, lsu_awready, lsu_wready, lsu_bvalid, lsu_bready;
  logic [SW-1:0] lsu_wstrb;
  logic          xb_arvalid, xb_rready, xb_awvalid, xb_wvalid, xb_bready;
  logic [AW-1:0] xb_araddr, xb_awaddr;
  logic [DW-1:0] xb_wdata, xb_rdata;
  logic [SW-1:0] xb_wstrb;
  logic          xb_arready, xb_rvalid, xb_awready, xb_wready, xb_bvalid;
  logic [1:0]    xb_rresp, xb_bresp;
  arb_state_e    dbg_state;

  ysyx_20020207_axi_arbiter #(.AW(AW), .DW(DW)) dut (
    .clock(clock), .rst_n(rst_n),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arready(ifu_arready),
    .ifu_rvalid(ifu_rvalid), .ifu_rresp(ifu_rresp), .ifu_rdata(ifu_rdata), .ifu_rready(ifu_rready),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arready(lsu_arready),
    .lsu_rvalid(lsu_rvalid), .lsu_rresp(lsu_rresp), .lsu_rdata(lsu_rdata), .lsu_rready(lsu_rready),
    .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_wvalid(lsu_wvalid),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_awready(lsu_awready),
    .lsu_wready(lsu_wready), .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp), .lsu_bready(lsu_bready),
    .xb_arvalid(xb_arvalid), .xb_araddr(xb_araddr), .xb_rready(xb_rready),
    .xb_awvalid(xb_awvalid), .xb_awaddr(xb_awaddr), .xb_wvalid(xb_wvalid),
    .xb_wdata(xb_wdata), .xb_wstrb(xb_wstrb), .xb_bready(xb_bready),
    .xb_arready(xb_arready), .xb_rvalid(xb_rvalid), .xb_rresp(xb_rresp), .xb_rdata(xb_rdata),
    .xb_awready(xb_awready), .xb_wready(xb_wready), .xb_bvalid(xb_bvalid), .xb_bresp(xb_bresp),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [AW:0]      grant_q[$];   // {is_write, addr} in expected xbar order
  logic [DW+SW-1:0] wdat_q[$];
  logic [DW+1:0]    ifu_exp_q[$]; // {rresp, rdata}
  logic [DW+1:0]    lsu_exp_q[$];
  logic [1:0]       b_exp_q[$];
  bit               model_last_lsu = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  // Slave contents are a fixed function of the address so responses are predictable.
  function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
    if (a == 32'h3000_0000) return 64'h1122_3344_5566_7788;
    return {a ^ 32'h5a5a_1234, ~a};
  endfunction
  function automatic logic [1:0] slave_rresp(input logic [AW-1:0] a);
    return a[5] ? RESP_SLVERR : RESP_OKAY;
  endfunction
  function automatic logic [1:0] slave_bresp(input logic [AW-1:0] a);
    return a[6] ? RESP_SLVERR : RESP_OKAY;
  endfunction
  function automatic logic [AW-1:0] rand_addr();
    return $urandom() & 32'hffff_fff8;
  endfunction

  function automatic logic all_outputs_or();
    return |{ifu_arready, ifu_rvalid, ifu_rresp, ifu_rdata, lsu_arready, lsu_rvalid, lsu_rresp,
             lsu_rdata, lsu_awready, lsu_wready, lsu_bvalid, lsu_bresp, xb_arvalid, xb_araddr,
             xb_rready, xb_awvalid, xb_awaddr, xb_wvalid, xb_wdata, xb_wstrb, xb_bready};
  endfunction

  // ---------------- behavioural xbar slave ----------------
  logic          sl_ar_hs, sl_r_hs, sl_aw_hs, sl_w_hs, sl_b_hs;
  logic [AW-1:0] sl_araddr, sl_awaddr, sl_rd_addr, sl_wr_addr;
  logic          sl_rd_pend, sl_aw_got, sl_w_got;
  int            sl_r_dly, sl_b_dly;

  initial begin
    xb_arready = 0; xb_rvalid = 0; xb_rresp = '0; xb_rdata = '0;
    xb_awready = 0; xb_wready = 0; xb_bvalid = 0; xb_bresp = '0;
    sl_rd_pend = 0; sl_aw_got = 0; sl_w_got = 0; sl_r_dly = 0; sl_b_dly = 0;
    sl_rd_addr = '0; sl_wr_addr = '0;
    forever begin
      @(negedge clock);
      sl_ar_hs = xb_arvalid & xb_arready;
      sl_r_hs  = xb_rvalid & xb_rready;
      sl_aw_hs = xb_awvalid & xb_awready;
      sl_w_hs  = xb_wvalid & xb_wready;
      sl_b_hs  = xb_bvalid & xb_bready;
      sl_araddr = xb_araddr;
      sl_awaddr = xb_awaddr;
      @(posedge clock); #1;
      if (!rst_n) begin
        xb_arready = 0; xb_rvalid = 0; xb_awready = 0; xb_wready = 0; xb_bvalid = 0;
        sl_rd_pend = 0; sl_aw_got = 0; sl_w_got = 0;
        continue;
      end
      if (sl_r_hs) xb_rvalid = 0;
      if (sl_ar_hs) begin
        sl_rd_pend = 1; sl_rd_addr = sl_araddr; sl_r_dly = $urandom_range(0, 3);
      end
      if (sl_rd_pend && !xb_rvalid) begin
        if (sl_r_dly == 0) begin
          xb_rvalid = 1; xb_rdata = slave_data(sl_rd_addr); xb_rresp = slave_rresp(sl_rd_addr);
          sl_rd_pend = 0;
        end else sl_r_dly--;
      end
      xb_arready = !sl_rd_pend && !xb_rvalid && ($urandom_range(0, 2) != 0);
      if (sl_b_hs) xb_bvalid = 0;
      if (sl_aw_hs) begin sl_aw_got = 1; sl_wr_addr = sl_awaddr; end
      if (sl_w_hs) sl_w_got = 1;
      if (sl_aw_got && sl_w_got && !xb_bvalid) begin
        if (sl_b_dly == 0) begin
          xb_bvalid = 1; xb_bresp = slave_bresp(sl_wr_addr);
          sl_aw_got = 0; sl_w_got = 0; sl_b_dly = $urandom_range(0, 3);
        end else sl_b_dly--;
      end
      xb_awready = !sl_aw_got && ($urandom_range(0, 2) != 0);
      xb_wready  = !sl_w_got && ($urandom_range(0, 2) != 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic          mon_exp_idle, mon_aw_seen, mon_w_seen;
  logic [AW:0]   mon_g;
  logic [DW+1:0] mon_r;

  initial begin
    mon_exp_idle = 0; mon_aw_seen = 0; mon_w_seen = 0;
    forever begin
      @(negedge clock);
      if (!rst_n) begin
        mon_exp_idle = 0; mon_aw_seen = 0; mon_w_seen = 0;
        continue;
      end
      if (mon_exp_idle) check("idle_after_resp", 128'(dbg_state), 128'(ARB_IDLE));
      mon_exp_idle = 0;
      if (dbg_state == ARB_IDLE) check("idle_outputs_zero", 128'(all_outputs_or()), 128'(0));
      if (mon_aw_seen) check("awvalid_masked", 128'(xb_awvalid), 128'(0));
      if (mon_w_seen)  check("wvalid_masked", 128'(xb_wvalid), 128'(0));
      if (xb_arvalid && xb_arready) begin
        if (grant_q.size() == 0) fail_now("grant_rd_unexpected");
        else begin
          mon_g = grant_q.pop_front();
          check("grant_rd", 128'({1'b0, xb_araddr}), 128'(mon_g));
        end
      end
      if (xb_awvalid && xb_awready) begin
        mon_aw_seen = 1;
        if (grant_q.size() == 0) fail_now("grant_wr_unexpected");
        else begin
          mon_g = grant_q.pop_front();
          check("grant_wr", 128'({1'b1, xb_awaddr}), 128'(mon_g));
        end
      end
      if (xb_wvalid && xb_wready) begin
        mon_w_seen = 1;
        if (wdat_q.size() == 0) fail_now("wdata_unexpected");
        else check("wdata_wstrb", 128'({xb_wdata, xb_wstrb}), 128'(wdat_q.pop_front()));
      end
      if (ifu_rvalid) check("lsu_quiet_on_ifu_r", 128'({lsu_rvalid, lsu_rresp, lsu_rdata}), 128'(0));
      if (lsu_rvalid) check("ifu_quiet_on_lsu_r", 128'({ifu_rvalid, ifu_rresp, ifu_rdata}), 128'(0));
      if (ifu_rvalid && ifu_rready) begin
        mon_exp_idle = 1;
        check("ifu_r_state", 128'(dbg_state), 128'(ARB_IFU_RD));
        if (ifu_exp_q.size() == 0) fail_now("ifu_r_unexpected");
        else begin
          mon_r = ifu_exp_q.pop_front();
          check("ifu_rresp_rdata", 128'({ifu_rresp, ifu_rdata}), 128'(mon_r));
        end
      end
      if (lsu_rvalid && lsu_rready) begin
        mon_exp_idle = 1;
        check("lsu_r_state", 128'(dbg_state), 128'(ARB_LSU_RD));
        if (lsu_exp_q.size() == 0) fail_now("lsu_r_unexpected");
        else begin
          mon_r = lsu_exp_q.pop_front();
          check("lsu_rresp_rdata", 128'({lsu_rresp, lsu_rdata}), 128'(mon_r));
        end
      end
      if (lsu_bvalid && lsu_bready) begin
        mon_exp_idle = 1; mon_aw_seen = 0; mon_w_seen = 0;
        check("b_state", 128'(dbg_state), 128'(ARB_LSU_WR));
        if (b_exp_q.size() == 0) fail_now("lsu_b_unexpected");
        else check("lsu_bresp", 128'(lsu_bresp), 128'(b_exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_queues();
    grant_q.delete(); wdat_q.delete(); ifu_exp_q.delete(); lsu_exp_q.delete(); b_exp_q.delete();
  endtask

  // All requested transactions are raised together and held until accepted.
  task automatic run_round(input bit do_ifu, input bit do_lrd, input bit do_lwr, input int hold_b,
                           input logic [AW-1:0] ifu_a, input logic [AW-1:0] lrd_a,
                           input logic [AW-1:0] lwr_a, input logic [SW-1:0] ws);
    bit p_ifu, p_lrd, p_aw, p_w, lazy, hs_ifu, hs_lrd, hs_aw, hs_w, hs_b;
    int b_cnt;
    logic [DW-1:0] wd;
    wd = {$urandom(), $urandom()};
    // Reference order: a write goes first, then reads with alternating tie-break.
    if (do_lwr) begin
      grant_q.push_back({1'b1, lwr_a});
      wdat_q.push_back({wd, ws});
      b_exp_q.push_back(slave_bresp(lwr_a));
    end
    if (do_ifu && do_lrd) begin
      if (model_last_lsu) begin
        grant_q.push_back({1'b0, ifu_a}); grant_q.push_back({1'b0, lrd_a});
      end else begin
        grant_q.push_back({1'b0, lrd_a}); grant_q.push_back({1'b0, ifu_a});
      end
    end else if (do_ifu) begin
      grant_q.push_back({1'b0, ifu_a}); model_last_lsu = 1'b0;
    end else if (do_lrd) begin
      grant_q.push_back({1'b0, lrd_a}); model_last_lsu = 1'b1;
    end
    if (do_ifu) ifu_exp_q.push_back({slave_rresp(ifu_a), slave_data(ifu_a)});
    if (do_lrd) lsu_exp_q.push_back({slave_rresp(lrd_a), slave_data(lrd_a)});

    @(posedge clock); #1;
    ifu_arvalid = do_ifu; ifu_araddr = ifu_a;
    lsu_arvalid = do_lrd; lsu_araddr = lrd_a;
    lsu_awvalid = do_lwr; lsu_awaddr = lwr_a;
    lsu_wvalid  = do_lwr; lsu_wdata  = wd; lsu_wstrb = ws;
    if (hold_b > 0) lsu_bready = 0;
    lazy = ($urandom_range(0, 1) == 1);
    p_ifu = do_ifu; p_lrd = do_lrd; p_aw = do_lwr; p_w = do_lwr;
    b_cnt = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (!(p_ifu || p_lrd || p_aw || p_w || ifu_exp_q.size() != 0 ||
            lsu_exp_q.size() != 0 || b_exp_q.size() != 0)) break;
      @(negedge clock);
      hs_ifu = ifu_arvalid & ifu_arready;
      hs_lrd = lsu_arvalid & lsu_arready;
      hs_aw  = lsu_awvalid & lsu_awready;
      hs_w   = lsu_wvalid & lsu_wready;
      hs_b   = lsu_bvalid & lsu_bready;
      if (hold_b > 0 && lsu_bvalid && !lsu_bready) begin
        check("b_hold_state", 128'(dbg_state), 128'(ARB_LSU_WR));
        check("b_hold_ifu_arready", 128'({ifu_arready, lsu_arready}), 128'(0));
        b_cnt++;
      end
      @(posedge clock); #1;
      if (hs_ifu) begin ifu_arvalid = 0; p_ifu = 0; end
      if (hs_lrd) begin lsu_arvalid = 0; p_lrd = 0; end
      if (hs_aw) begin p_aw = 0; if (!lazy) lsu_awvalid = 0; end
      if (hs_w)  begin p_w = 0;  if (!lazy) lsu_wvalid = 0; end
      if (hs_b)  begin lsu_awvalid = 0; lsu_wvalid = 0; end
      ifu_rready = ($urandom_range(0, 3) != 0);
      lsu_rready = ($urandom_range(0, 3) != 0);
      lsu_bready = (hold_b > 0) ? (b_cnt >= hold_b) : ($urandom_range(0, 3) != 0);
    end
    if (p_ifu || p_lrd || p_aw || p_w || ifu_exp_q.size() != 0 || lsu_exp_q.size() != 0 ||
        b_exp_q.size() != 0 || grant_q.size() != 0) begin
      fail_now("round_timeout");
      clear_queues();
    end
    if (hold_b > 0) check("b_hold_cycles", 128'(b_cnt), 128'(hold_b));
    ifu_arvalid = 0; lsu_arvalid = 0; lsu_awvalid = 0; lsu_wvalid = 0;
  endtask

  // Reset asserted while the LSU owns a read.
  task automatic reset_mid_lsu_read(input logic [AW-1:0] a);
    bit reached;
    reached = 0;
    @(posedge clock); #1;
    lsu_rready = 0;
    lsu_arvalid = 1; lsu_araddr = a;
    grant_q.push_back({1'b0, a});
    lsu_exp_q.push_back({slave_rresp(a), slave_data(a)});
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clock);
      if (dbg_state == ARB_LSU_RD) begin reached = 1; break; end
    end
    check("reached_lsu_rd", 128'(reached), 128'(1));
    #2 rst_n = 0;
    #1;
    check("reset_outputs_zero", 128'(all_outputs_or()), 128'(0));
    check("reset_state_idle", 128'(dbg_state), 128'(ARB_IDLE));
    lsu_arvalid = 0;
    clear_queues();
    model_last_lsu = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst_n = 1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit b_ifu, b_lrd, b_lwr;
    ifu_arvalid = 0; ifu_araddr = '0; ifu_rready = 0;
    lsu_arvalid = 0; lsu_araddr = '0; lsu_rready = 0;
    lsu_awvalid = 0; lsu_awaddr = '0; lsu_wvalid = 0; lsu_wdata = '0; lsu_wstrb = '0;
    lsu_bready = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("por_outputs_zero", 128'(all_outputs_or()), 128'(0));
    check("por_state_idle", 128'(dbg_state), 128'(ARB_IDLE));
    rst_n = 1;

    run_round(1, 0, 0, 0, 32'h3000_0000, '0, '0, '0);
    repeat (4) run_round(1, 1, 0, 0, rand_addr(), rand_addr(), '0, '0);
    run_round(1, 0, 1, 0, 32'h3000_0020, '0, 32'h0f00_0008, 8'hff);
    run_round(1, 0, 1, 5, rand_addr(), '0, rand_addr(), 8'h0f);
    run_round(0, 1, 0, 0, '0, 32'h3000_0020, '0, '0);
    reset_mid_lsu_read(rand_addr());
    run_round(1, 1, 0, 0, rand_addr(), rand_addr(), '0, '0);
    repeat (40) begin
      b_ifu = ($urandom_range(0, 1) == 1);
      b_lrd = ($urandom_range(0, 1) == 1);
      b_lwr = ($urandom_range(0, 2) == 0);
      if (b_ifu || b_lrd || b_lwr)
        run_round(b_ifu, b_lrd, b_lwr, 0, rand_addr(), rand_addr(), rand_addr(),
                  SW'($urandom_range(1, 255)));
    end
    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
